// File: rtl/dmem_write_buffer_if.sv
// RAM status encoding plus the bundled access-logic and RAM-port signals
// of the data-memory write buffer.
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

interface dmem_write_buffer_if;
  import cpu_types_pkg::*;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] ddata;
  logic        dready;
  logic        wempty;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  modport slave (
    input  dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ddata, dready, wempty, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ddata, dready, wempty, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-store write buffer between the data-cache access logic and RAM:
// stores queue in a FIFO and drain in the background, loads forward or read RAM.
module dmem_write_buffer
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 CLK,
  input logic                 nRST,
  dmem_write_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q [DEPTH];
  logic [31:0]        data_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        ddata_q, ddata_d;
  logic               dready_q, dready_d;

  logic               reqLive;
  logic               storeReq;
  logic               loadReq;
  logic               loadMiss;
  logic               fwdHit;
  logic [31:0]        fwdData;
  logic [PTR_W-1:0]   fwdIdx;
  logic               popNow;
  logic               full;
  logic               push;
  logic               ramRENc;
  logic               ramWENc;
  logic [31:0]        ramAddrC;
  logic [31:0]        ramStoreC;

  // A request seen in its own dready cycle is the one just completed, so it is masked.
  assign reqLive  = (bus.dREN | bus.dWEN) & ~dready_q;
  assign storeReq = reqLive & bus.dWEN;
  assign loadReq  = reqLive & bus.dREN & ~bus.dWEN;

  assign popNow   = (state_q == DRAIN) && (bus.ramstate == ACCESS);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign push     = storeReq & (~full | popNow);
  assign loadMiss = loadReq & ~fwdHit;

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    fwdIdx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwdIdx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[fwdIdx][31:2] == bus.daddr[31:2])) begin
        fwdHit  = 1'b1;
        fwdData = data_q[fwdIdx];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dready_d  = 1'b0;
    ddata_d   = ddata_q;
    ramRENc   = 1'b0;
    ramWENc   = 1'b0;
    ramAddrC  = '0;
    ramStoreC = '0;

    case (state_q)
      IDLE: begin
        if (loadMiss) begin
          state_d = READ;
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        ramWENc   = 1'b1;
        ramAddrC  = addr_q[head_q];
        ramStoreC = data_q[head_q];
        if (popNow) begin
          state_d = IDLE;
        end
      end
      READ: begin
        ramRENc  = 1'b1;
        ramAddrC = bus.daddr;
        if (bus.ramstate == ACCESS) begin
          state_d  = IDLE;
          dready_d = 1'b1;
          ddata_d  = bus.ramload;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push) begin
      dready_d = 1'b1;
    end
    if (loadReq && fwdHit && (state_q != READ)) begin
      dready_d = 1'b1;
      ddata_d  = fwdData;
    end
  end

  // A push and a pop in the same cycle leave the count unchanged.
  always_comb begin
    head_d  = head_q + PTR_W'(popNow);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(popNow);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      ddata_q  <= '0;
      dready_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      ddata_q  <= ddata_d;
      dready_q <= dready_d;
      if (push) begin
        addr_q[tail_q] <= bus.daddr;
        data_q[tail_q] <= bus.dstore;
      end
    end
  end

  assign bus.ddata    = ddata_q;
  assign bus.dready   = dready_q;
  assign bus.wempty   = (count_q == '0);
  assign bus.ramREN   = ramRENc;
  assign bus.ramWEN   = ramWENc;
  assign bus.ramaddr  = ramAddrC;
  assign bus.ramstore = ramStoreC;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: a simple RAM responder plus
// scenario tasks for forwarding, ordering, full-buffer, miss and retry cases.
module tb_dmem_write_buffer;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;

  dmem_write_buffer_if ifc();

  dmem_write_buffer #(.DEPTH(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (ifc)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] expLoadQ[$];
  logic [63:0] expWrQ[$];
  bit          autoRam = 0;
  int          ramLatency = 0;
  int          latCnt = 0;
  ramstate_t   manualState = FREE;
  bit          curIsLoad = 0;
  bit          sawRamREN = 0;
  bit          prevDready = 0;
  int          readAccessCyc = -10;

  function automatic logic [31:0] ramFn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One clock: RAM responder and scoreboard at the falling edge, then return 1 time unit past the rising edge.
  task automatic stepCycle();
    logic [63:0] expW;
    logic [31:0] expD;
    @(negedge CLK);
    if (autoRam) begin
      if (ifc.ramWEN || ifc.ramREN) begin
        if (latCnt >= ramLatency) begin
          ifc.ramstate = ACCESS;
          latCnt = 0;
          if (ifc.ramREN) begin
            ifc.ramload = ramFn(ifc.ramaddr);
            readAccessCyc = cyc;
          end
        end else begin
          ifc.ramstate = BUSY;
          latCnt++;
        end
      end else begin
        ifc.ramstate = FREE;
        latCnt = 0;
      end
    end else begin
      ifc.ramstate = manualState;
    end
    if (ifc.ramREN === 1'b1) sawRamREN = 1;
    if (nRST && ifc.ramstate == ACCESS && ifc.ramWEN === 1'b1) begin
      checks++;
      if (expWrQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL ram_write_unexpected got addr=%h data=%h required none", ifc.ramaddr, ifc.ramstore);
      end else begin
        expW = expWrQ.pop_front();
        if ({ifc.ramaddr, ifc.ramstore} !== expW) begin
          failures++;
          $display("[TB] FAIL ram_write_order got %h_%h required %h_%h", ifc.ramaddr, ifc.ramstore, expW[63:32], expW[31:0]);
        end
      end
    end
    if (nRST && ifc.dready === 1'b1) begin
      checks++;
      if (prevDready) begin
        failures++;
        $display("[TB] FAIL dready_double got 1 in consecutive cycles required single pulse");
      end
      if (curIsLoad) begin
        checks++;
        if (expLoadQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL load_unexpected got ddata=%h required none", ifc.ddata);
        end else begin
          expD = expLoadQ.pop_front();
          if (ifc.ddata !== expD) begin
            failures++;
            $display("[TB] FAIL load_data got %h required %h", ifc.ddata, expD);
          end
        end
      end
    end
    prevDready = nRST && (ifc.dready === 1'b1);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic issueStore(input logic [31:0] addr, input logic [31:0] data, output int n);
    curIsLoad  = 0;
    ifc.dREN   = 1'b0;
    ifc.dWEN   = 1'b1;
    ifc.daddr  = addr;
    ifc.dstore = data;
    expWrQ.push_back({addr, data});
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (ifc.dready !== 1'b1 && n < 200);
    checks++;
    if (ifc.dready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL store_timeout got no dready after %0d cycles required dready", n);
    end
    ifc.dWEN = 1'b0;
    stepCycle();
  endtask

  task automatic issueLoad(input logic [31:0] addr, input logic [31:0] expData, output int n);
    curIsLoad = 1;
    ifc.dWEN  = 1'b0;
    ifc.dREN  = 1'b1;
    ifc.daddr = addr;
    expLoadQ.push_back(expData);
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (ifc.dready !== 1'b1 && n < 200);
    checks++;
    if (ifc.dready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_timeout got no dready after %0d cycles required dready", n);
    end
    ifc.dREN = 1'b0;
    stepCycle();
  endtask

  task automatic drainAll(input int lat);
    int n;
    autoRam    = 1;
    ramLatency = lat;
    n = 0;
    while ((ifc.wempty !== 1'b1 || ifc.ramWEN !== 1'b0) && n < 100) begin
      stepCycle();
      n++;
    end
    checks++;
    if (ifc.wempty !== 1'b1 || expWrQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_complete got wempty=%b pending=%0d required wempty=1 pending=0", ifc.wempty, expWrQ.size());
    end
  endtask

  task automatic test_reset();
    nRST        = 1'b0;
    ifc.dREN    = 1'b1;
    ifc.dWEN    = 1'b1;
    ifc.daddr   = 32'h100;
    ifc.dstore  = 32'h1234;
    autoRam     = 0;
    manualState = ACCESS;
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ifc.ramREN, ifc.ramWEN, ifc.ramaddr, ifc.ramstore, ifc.ddata, ifc.dready, ifc.wempty}
          !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
        failures++;
        $display("[TB] FAIL reset_outputs got ren=%b wen=%b addr=%h store=%h ddata=%h dready=%b wempty=%b required all 0, wempty=1",
                 ifc.ramREN, ifc.ramWEN, ifc.ramaddr, ifc.ramstore, ifc.ddata, ifc.dready, ifc.wempty);
      end
      stepCycle();
    end
    ifc.dREN    = 1'b0;
    ifc.dWEN    = 1'b0;
    manualState = FREE;
    nRST        = 1'b1;
    stepCycle();
    checks++;
    if (ifc.dready !== 1'b0 || ifc.wempty !== 1'b1 || ifc.ramWEN !== 1'b0 || ifc.ramREN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release got dready=%b wempty=%b wen=%b ren=%b required 0 1 0 0",
               ifc.dready, ifc.wempty, ifc.ramWEN, ifc.ramREN);
    end
  endtask

  task automatic test_forward();
    int n;
    autoRam     = 0;
    manualState = BUSY;
    sawRamREN   = 0;
    issueStore(32'h100, 32'hDEADBEEF, n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("[TB] FAIL store_latency got %0d required 1", n);
    end
    issueLoad(32'h100, 32'hDEADBEEF, n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("[TB] FAIL fwd_latency got %0d required 1", n);
    end
    checks++;
    if (sawRamREN || ifc.wempty !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fwd_no_ram got ramREN_seen=%0d wempty=%b required 0 0", sawRamREN, ifc.wempty);
    end
    drainAll(1);
  endtask

  task automatic test_youngest();
    int n;
    autoRam     = 0;
    manualState = BUSY;
    issueStore(32'h200, 32'h1, n);
    issueStore(32'h200, 32'h2, n);
    issueLoad(32'h200, 32'h2, n);
    issueLoad(32'h203, 32'h2, n);
    drainAll(2);
  endtask

  task automatic test_full();
    int n;
    autoRam     = 0;
    manualState = BUSY;
    for (int i = 0; i < 4; i++) begin
      issueStore(32'h600 + 32'(4 * i), 32'h1000 + 32'(i), n);
      checks++;
      if (n != 1) begin
        failures++;
        $display("[TB] FAIL fill_latency entry=%0d got %0d required 1", i, n);
      end
    end
    curIsLoad  = 0;
    ifc.dWEN   = 1'b1;
    ifc.daddr  = 32'h610;
    ifc.dstore = 32'h1004;
    expWrQ.push_back({32'h610, 32'h1004});
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checks++;
      if (ifc.dready !== 1'b0 || ifc.wempty !== 1'b0) begin
        failures++;
        $display("[TB] FAIL full_hold got dready=%b wempty=%b required 0 0", ifc.dready, ifc.wempty);
      end
    end
    manualState = ACCESS;
    stepCycle();
    manualState = BUSY;
    checks++;
    if (ifc.dready !== 1'b1 || ifc.ramWEN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_accept_on_pop got dready=%b ramWEN=%b required 1 0", ifc.dready, ifc.ramWEN);
    end
    ifc.dWEN = 1'b0;
    stepCycle();
    ifc.dWEN   = 1'b1;
    ifc.daddr  = 32'h614;
    ifc.dstore = 32'h1005;
    expWrQ.push_back({32'h614, 32'h1005});
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checks++;
      if (ifc.dready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL count_stays_full got dready=%b required 0", ifc.dready);
      end
    end
    autoRam    = 1;
    ramLatency = 0;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (ifc.dready !== 1'b1 && n < 50);
    checks++;
    if (ifc.dready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sixth_store_timeout got no dready required dready");
    end
    ifc.dWEN = 1'b0;
    stepCycle();
    drainAll(0);
  endtask

  task automatic test_miss_during_drain();
    int n;
    bit seenREN;
    autoRam    = 1;
    ramLatency = 3;
    issueStore(32'h400, 32'h55, n);
    checks++;
    if (ifc.ramWEN !== 1'b1) begin
      failures++;
      $display("[TB] FAIL miss_setup got ramWEN=%b required 1", ifc.ramWEN);
    end
    curIsLoad = 1;
    ifc.dREN  = 1'b1;
    ifc.daddr = 32'h300;
    expLoadQ.push_back(ramFn(32'h300));
    seenREN = 0;
    n = 0;
    do begin
      stepCycle();
      n++;
      if (ifc.ramREN === 1'b1 && !seenREN) begin
        seenREN = 1;
        checks++;
        if (ifc.wempty !== 1'b1 || ifc.ramWEN !== 1'b0 || ifc.ramaddr !== 32'h300) begin
          failures++;
          $display("[TB] FAIL miss_after_drain got wempty=%b wen=%b addr=%h required 1 0 00000300",
                   ifc.wempty, ifc.ramWEN, ifc.ramaddr);
        end
      end
    end while (ifc.dready !== 1'b1 && n < 100);
    checks++;
    if (ifc.dready !== 1'b1 || !seenREN) begin
      failures++;
      $display("[TB] FAIL miss_timeout got dready=%b ramREN_seen=%0d required 1 1", ifc.dready, seenREN);
    end
    checks++;
    if (cyc != readAccessCyc + 1) begin
      failures++;
      $display("[TB] FAIL miss_timing got dready cycle %0d required %0d", cyc, readAccessCyc + 1);
    end
    ifc.dREN = 1'b0;
    stepCycle();
  endtask

  task automatic test_error_retry();
    int n;
    autoRam     = 0;
    manualState = BUSY;
    issueStore(32'h500, 32'hCAFEF00D, n);
    n = 0;
    while (ifc.ramWEN !== 1'b1 && n < 10) begin
      stepCycle();
      n++;
    end
    manualState = ERROR;
    for (int i = 0; i < 2; i++) begin
      stepCycle();
      checks++;
      if (ifc.ramWEN !== 1'b1 || ifc.ramaddr !== 32'h500 || ifc.ramstore !== 32'hCAFEF00D) begin
        failures++;
        $display("[TB] FAIL error_hold got wen=%b addr=%h store=%h required 1 00000500 cafef00d",
                 ifc.ramWEN, ifc.ramaddr, ifc.ramstore);
      end
    end
    manualState = ACCESS;
    stepCycle();
    manualState = BUSY;
    checks++;
    if (ifc.ramWEN !== 1'b0 || ifc.wempty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL error_pop got wen=%b wempty=%b required 0 1", ifc.ramWEN, ifc.wempty);
    end
    for (int i = 0; i < 3; i++) stepCycle();
    checks++;
    if (ifc.ramWEN !== 1'b0 || ifc.wempty !== 1'b1 || expWrQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL error_single_pop got wen=%b wempty=%b pending=%0d required 0 1 0",
               ifc.ramWEN, ifc.wempty, expWrQ.size());
    end
  endtask

  initial begin
    nRST         = 1'b0;
    ifc.dREN     = 1'b0;
    ifc.dWEN     = 1'b0;
    ifc.daddr    = '0;
    ifc.dstore   = '0;
    ifc.ramload  = '0;
    ifc.ramstate = FREE;
    test_reset();
    test_forward();
    test_youngest();
    test_full();
    test_miss_during_drain();
    test_error_retry();
    checks++;
    if (expLoadQ.size() != 0 || expWrQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover got loads=%0d writes=%0d required 0 0", expLoadQ.size(), expWrQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
